// File: rtl/misc_arbiter.sv
// Two-requester round-robin front end for the misc/I-O manager.
// Serialises requests into one manager command at a time and returns each result to its requester.
module misc_arbiter #(
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req0_op,
    input  logic [DATA_SIZE-1:0] req0_port,
    input  logic [DATA_SIZE-1:0] req0_data,
    input  logic [3:0]           req1_op,
    input  logic [DATA_SIZE-1:0] req1_port,
    input  logic [DATA_SIZE-1:0] req1_data,
    output logic [1:0]           resp_valid,
    output logic                 resp_err,
    output logic [DATA_SIZE-1:0] resp_data,
    output logic                 mm_cs,
    output logic [3:0]           mm_op,
    output logic [DATA_SIZE-1:0] mm_port,
    output logic [DATA_SIZE-1:0] mm_data,
    input  logic [DATA_SIZE-1:0] mm_result
);

    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;       // requester favoured when both are valid
    logic                 idx_q, idx_d;
    logic                 mm_cs_q, mm_cs_d;
    logic [3:0]           mm_op_q, mm_op_d;
    logic [DATA_SIZE-1:0] mm_port_q, mm_port_d;
    logic [DATA_SIZE-1:0] mm_data_q, mm_data_d;
    logic [1:0]           resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [DATA_SIZE-1:0] resp_data_q, resp_data_d;

    logic                 gnt;
    logic                 accept;
    logic [3:0]           sel_op;
    logic [DATA_SIZE-1:0] sel_port;
    logic [DATA_SIZE-1:0] sel_data;

    always_comb begin
        gnt       = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ptr_q;
            default: gnt = 1'b0;
        endcase
        // Gated by rstn so the strobe is forced low for the whole reset, not just after an edge.
        if (state_q == S_IDLE && rstn && (req_valid != 2'b00)) begin
            req_ready[gnt] = 1'b1;
        end
        accept   = (req_ready != 2'b00);
        sel_op   = gnt ? req1_op   : req0_op;
        sel_port = gnt ? req1_port : req0_port;
        sel_data = gnt ? req1_data : req0_data;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        mm_cs_d      = mm_cs_q;
        mm_op_d      = mm_op_q;
        mm_port_d    = mm_port_q;
        mm_data_d    = mm_data_q;
        resp_valid_d = 2'b00;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d = gnt;
                    ptr_d = ~gnt;
                    if (sel_op[3:2] == 2'b00) begin
                        mm_op_d   = sel_op;
                        mm_port_d = sel_port;
                        mm_data_d = sel_data;
                        mm_cs_d   = sel_op[1];
                        state_d   = S_ISSUE;
                    end else begin
                        resp_valid_d[gnt] = 1'b1;
                        resp_err_d        = 1'b1;
                        resp_data_d       = '0;
                        state_d           = S_RESP;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                resp_valid_d[idx_q] = 1'b1;
                resp_err_d          = 1'b0;
                resp_data_d         = mm_result;
                mm_cs_d             = 1'b0;
                mm_op_d             = OP_NOP;
                mm_port_d           = '0;
                mm_data_d           = '0;
                state_d             = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            idx_q        <= 1'b0;
            mm_cs_q      <= 1'b0;
            mm_op_q      <= OP_NOP;
            mm_port_q    <= '0;
            mm_data_q    <= '0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            mm_cs_q      <= mm_cs_d;
            mm_op_q      <= mm_op_d;
            mm_port_q    <= mm_port_d;
            mm_data_q    <= mm_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign mm_cs      = mm_cs_q;
    assign mm_op      = mm_op_q;
    assign mm_port    = mm_port_q;
    assign mm_data    = mm_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;

endmodule

// File: doc/misc_arbiter.md
MISC_ARBITER -- requirements
Module: misc_arbiter

Interface
REQ-001: Parameter DATA_SIZE, default 16, width of port/data/result buses; SHALL match the width of the misc/I-O manager it drives.
REQ-002: clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003: rstn  input  1  reset; asynchronous, active-low.
REQ-004: req_valid  input  2  per-requester request valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-005: req_ready  output  2  per-requester accept strobe.
REQ-006: req0_op, req1_op  input  4 each  requested operation code.
REQ-007: req0_port, req1_port  input  DATA_SIZE each  RAM address / I-O port number.
REQ-008: req0_data, req1_data  input  DATA_SIZE each  write / send data.
REQ-009: resp_valid  output  2  per-requester one-cycle completion pulse.
REQ-010: resp_err  output  1  set with resp_valid when the op was rejected.
REQ-011: resp_data  output  DATA_SIZE  result of the completed request, shared by both requesters.
REQ-012: mm_cs, mm_op, mm_port, mm_data  output  1/4/DATA_SIZE/DATA_SIZE  command to the misc manager.
REQ-013: mm_result  input  DATA_SIZE  result from the misc manager.

Function
REQ-014: Legal ops SHALL be 0000 RAM read, 0001 RAM write, 0010 port receive, 0011 port send; every other code SHALL be illegal.
REQ-015: FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-016: In IDLE, req_ready SHALL be asserted for exactly one requester (the grantee), and only when that requester's req_valid is high.
REQ-017: Grantee selection:
- only one valid -> that requester;
- both valid -> the requester not served last (round-robin pointer);
- pointer SHALL update on every accept, including illegal ops.
REQ-018: Accept occurs when req_valid[i] and req_ready[i] are high on the same edge; the arbiter SHALL register op/port/data and the requester index on that edge.
REQ-019: On accepting a legal op, the FSM SHALL go IDLE->ISSUE; mm_op/mm_port/mm_data SHALL carry the request from that edge and stay stable through ISSUE and WAIT.
REQ-020: mm_cs SHALL be 1 during ISSUE/WAIT only for ops 0010/0011, and 0 otherwise.
REQ-021: Sequencing after accept:
- ISSUE->WAIT unconditionally on the next edge;
- WAIT->RESP on the following edge, capturing mm_result into resp_data on that edge.
REQ-022: In RESP, resp_valid[index] SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; accept-to-resp_valid latency SHALL be 3 cycles, and the next accept SHALL be possible at the earliest 4 cycles after the previous one.
REQ-023: On accepting an illegal op, the FSM SHALL go IDLE->RESP directly:
- mm_* SHALL stay idle;
- resp_data SHALL be 0;
- resp_err SHALL be 1;
- resp_valid SHALL appear 1 cycle after accept.
REQ-024: Outside ISSUE/WAIT, mm_op SHALL be 1111 (manager no-op), mm_cs 0, and mm_port/mm_data 0, so that no RAM read/write or I/O is triggered.
REQ-025: resp_data and resp_err SHALL hold their values until the next completion.
REQ-026: resp_err SHALL be 0 for legal ops.
REQ-027: req_* changes while not accepted SHALL have no effect; a dropped req_valid before accept SHALL be legal and SHALL NOT update the pointer.
REQ-028: A requester SHALL NOT be granted twice in a row while the other holds req_valid high in IDLE.

Reset
REQ-029: While rstn is low, regardless of clk, the block SHALL force:
- FSM to IDLE;
- pointer favouring requester 0;
- req_ready = 00, resp_valid = 00, resp_err = 0, resp_data = 0;
- mm_cs = 0, mm_op = 1111, mm_port = 0, mm_data = 0.
REQ-030: Reset asserted mid-transaction SHALL abort the transaction with no resp_valid and no further mm_* activity.
REQ-031: After rstn deasserts, the first grant SHALL be possible on the next edge.

Verification
REQ-032: Single legal read: req0 op 0000, port 5; mm_result = 0x1234 -> mm_op = 0000 for 2 cycles, resp_valid = 01 3 cycles after accept, resp_data = 0x1234, resp_err = 0.
REQ-033: Both requesters valid continuously with op 0011 -> grants alternate 0,1,0,1 starting with 0; mm_cs = 1 in ISSUE/WAIT; SEND issued once per accept.
REQ-034: Illegal op 0111 from req1 -> no mm_* change (mm_op = 1111), resp_valid = 10 1 cycle after accept, resp_err = 1, resp_data = 0.
REQ-035: Write: req1 op 0001, port 9, data 0xBEEF -> mm_cs = 0, mm_data = 0xBEEF during ISSUE/WAIT; then a read from port 9 returns 0xBEEF.
REQ-036: rstn pulsed low during WAIT -> mm_op = 1111 immediately (asynchronous), no resp_valid; after release, a req1-only request is accepted on the next edge.
REQ-037: req0 raises and drops req_valid during req1's transaction -> no grant to req0 and no pointer change.
